nf10_stamp_arbiter: RTL and testbench
=====================================

NF10_STAMP_ARBITER -- requirements
Module: nf10_stamp_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of stamp requesters (2..8).
REQ-002 SHALL have parameter TIMESTAMP_WIDTH, default 64: stamp width.
REQ-003 SHALL have parameter DROP_CNT_WIDTH, default 16: drop counter width.
REQ-004 SHALL have port S_AXI_ACLK, input, 1: the only clock; all logic on its rising edge.
REQ-005 SHALL have port S_AXI_ARESETN, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port STAMP_COUNTER, input, TIMESTAMP_WIDTH: free-running time from the timestamp block.
REQ-007 SHALL have port STAMP_REQ, input, NUM_PORTS: one-cycle capture pulse per requester.
REQ-008 SHALL have port M_STAMP_TDATA, output, TIMESTAMP_WIDTH: captured stamp.
REQ-009 SHALL have port M_STAMP_TUSER, output, clog2(NUM_PORTS): index of the originating port.
REQ-010 SHALL have port M_STAMP_TVALID, output, 1, and M_STAMP_TREADY, input, 1: output handshake.
REQ-011 SHALL have port DROP_FLAG, output, NUM_PORTS: sticky per-port overflow flags.
REQ-012 SHALL have port DROP_COUNT, output, DROP_CNT_WIDTH: total dropped requests.
REQ-013 SHALL have port DROP_CLEAR, input, 1: pulse that clears DROP_FLAG and DROP_COUNT.

Function
REQ-014 On STAMP_REQ[i]=1 with slot i free, the block SHALL, at that edge, set pending[i] and store STAMP_COUNTER in snapshot[i], giving zero added capture skew.
REQ-015 A slot SHALL count as free if pending[i]=0, or if slot i is being moved to the output register in the same cycle (the new request is accepted).
REQ-016 STAMP_REQ[i] with slot i not free SHALL be dropped: snapshot[i] is unchanged (oldest kept), DROP_FLAG[i] is set, and DROP_COUNT increments once per dropped request, saturating at all-ones.
REQ-017 Simultaneous drops on k ports in one cycle SHALL add k to DROP_COUNT, saturating.
REQ-018 DROP_CLEAR SHALL zero DROP_FLAG and DROP_COUNT; a drop in the same cycle SHALL win (flag set, count = number of drops in that cycle).
REQ-019 The FSM SHALL have two states, IDLE and VALID.
REQ-020 In IDLE with any pending bit set, the block SHALL load the selected snapshot and its port index into the output register, clear that pending bit, assert M_STAMP_TVALID and enter VALID.
REQ-021 In VALID, TDATA and TUSER SHALL stay stable while TVALID=1 and TREADY=0.
REQ-022 In VALID, on TVALID&TREADY: if any pending bit is set, the block SHALL reload in the same edge (back-to-back, one stamp per cycle); otherwise it SHALL deassert TVALID and return to IDLE.
REQ-023 Selection SHALL be round-robin, searching from last_grant+1 upward with wrap-around to 0; last_grant updates on every load.
REQ-024 Latency SHALL be one cycle: a request sampled at edge N with the output idle gives TVALID=1 after edge N+1.
REQ-025 No stamp SHALL be duplicated, reordered within a port, or lost, except as counted in DROP_COUNT.

Reset
REQ-026 While S_AXI_ARESETN=0 at a clock edge, the block SHALL set: state IDLE; M_STAMP_TVALID=0; M_STAMP_TDATA=0; M_STAMP_TUSER=0; pending=0; snapshot=0; DROP_FLAG=0; DROP_COUNT=0; last_grant=NUM_PORTS-1, so port 0 has first priority.
REQ-027 Reset asserted mid-transfer SHALL discard the held output and all pending stamps without counting drops; STAMP_REQ SHALL be ignored during reset.

Structure
REQ-028 Package nf10_stamp_pkg SHALL hold the FSM state encoding, default TIMESTAMP_WIDTH and DROP_CNT_WIDTH, and the port-index width function.
REQ-029 Round-robin selection SHALL be in sub-module nf10_rr_arbiter (request vector, last_grant in; one-hot grant, index, any_valid out; purely combinational).

Verification
REQ-030 Single request: STAMP_REQ[2] at STAMP_COUNTER=0x100, TREADY=1 -> one cycle later TVALID=1, TDATA=0x100, TUSER=2; then TVALID=0.
REQ-031 Simultaneous: STAMP_REQ=4'b1111 at counter 0x200, TREADY=1 after reset -> four consecutive beats, TUSER 0,1,2,3, all TDATA=0x200.
REQ-032 Backpressure: one stamp pending, TREADY low for 5 cycles -> TVALID, TDATA and TUSER stable for all 5; exactly one beat on release.
REQ-033 Drop: TREADY=0, STAMP_REQ[1] at 0x10 and again at 0x20 -> DROP_FLAG[1]=1, DROP_COUNT=1, delivered TDATA=0x10; DROP_CLEAR -> both zero.
REQ-034 Fairness: last grant port 2, pending ports 1 and 3 -> port 3 first, then port 1.
REQ-035 Reset mid-operation: two stamps pending, TVALID=1; assert S_AXI_ARESETN=0 for one cycle -> TVALID=0, no beats afterwards, DROP_COUNT=0.

Source files
------------

// File: rtl/nf10_stamp_pkg.sv
// nf10_stamp_pkg
//   Shared definitions for the timestamp arbiter slice: output FSM state
//   encoding, default stamp/drop-counter widths and the port-index width
//   helper used to size TUSER and the arbiter index.
package nf10_stamp_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } stamp_state_t;

    localparam int DEF_TIMESTAMP_WIDTH = 64;
    localparam int DEF_DROP_CNT_WIDTH  = 16;

    // Width of a port index; never below one bit so single-bit ports stay legal.
    function automatic int port_idx_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/nf10_rr_arbiter.sv
// nf10_rr_arbiter
//   Purely combinational round-robin picker. Searches the request vector
//   starting at last_grant+1 and wrapping to 0.
//   Ports:
//     req        - per-port request bits
//     last_grant - index granted most recently
//     grant      - one-hot grant (all zero when nothing requests)
//     grant_idx  - binary index of the granted port
//     any_valid  - at least one request present
module nf10_rr_arbiter
    import nf10_stamp_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = port_idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 any_valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        cand      = '0;
        // Offset NUM_PORTS comes back to last_grant itself, so it is checked last.
        for (int off = 1; off <= NUM_PORTS; off++) begin
            cand = IDX_W'((int'(last_grant) + off) % NUM_PORTS);
            if (!any_valid && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                any_valid   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nf10_stamp_arbiter.sv
// nf10_stamp_arbiter
//   Captures STAMP_COUNTER into a per-port snapshot slot on each STAMP_REQ
//   pulse and streams the captured stamps out one at a time, round-robin,
//   over an AXI-Stream style handshake. Each port holds one stamp; a request
//   hitting an occupied slot is dropped (oldest kept) and counted.
//   Ports:
//     S_AXI_ACLK, S_AXI_ARESETN - clock, synchronous active-low reset
//     STAMP_COUNTER             - free-running time value
//     STAMP_REQ                 - per-port one-cycle capture pulses
//     M_STAMP_TDATA/TUSER       - stamp value and originating port
//     M_STAMP_TVALID/TREADY     - output handshake
//     DROP_FLAG, DROP_COUNT     - sticky per-port drop flags, saturating total
//     DROP_CLEAR                - clears flags and count (same-cycle drops win)
module nf10_stamp_arbiter
    import nf10_stamp_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int TIMESTAMP_WIDTH = DEF_TIMESTAMP_WIDTH,
    parameter int DROP_CNT_WIDTH  = DEF_DROP_CNT_WIDTH
) (
    input  logic                                  S_AXI_ACLK,
    input  logic                                  S_AXI_ARESETN,
    input  logic [TIMESTAMP_WIDTH-1:0]            STAMP_COUNTER,
    input  logic [NUM_PORTS-1:0]                  STAMP_REQ,
    output logic [TIMESTAMP_WIDTH-1:0]            M_STAMP_TDATA,
    output logic [port_idx_width(NUM_PORTS)-1:0]  M_STAMP_TUSER,
    output logic                                  M_STAMP_TVALID,
    input  logic                                  M_STAMP_TREADY,
    output logic [NUM_PORTS-1:0]                  DROP_FLAG,
    output logic [DROP_CNT_WIDTH-1:0]             DROP_COUNT,
    input  logic                                  DROP_CLEAR
);

    localparam int IDX_W = port_idx_width(NUM_PORTS);
    localparam int SUM_W = DROP_CNT_WIDTH + 4;  // room for up to 8 drops per cycle
    localparam logic [IDX_W-1:0]          LAST_RST = IDX_W'(NUM_PORTS - 1);
    localparam logic [DROP_CNT_WIDTH-1:0] CNT_MAX  = '1;

    stamp_state_t state, state_nxt;

    logic [NUM_PORTS-1:0]                       pending;
    logic [NUM_PORTS-1:0][TIMESTAMP_WIDTH-1:0]  snapshot;
    logic [IDX_W-1:0]                           last_grant;

    logic [NUM_PORTS-1:0] grant, taken, slot_free, accept, drop;
    logic [IDX_W-1:0]     grant_idx;
    logic                 any_pending;
    logic                 load;

    logic [SUM_W-1:0]          drop_k, cnt_sum;
    logic [DROP_CNT_WIDTH-1:0] cnt_nxt;

    nf10_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr (
        .req        (pending),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any_valid  (any_pending)
    );

    // Output FSM: load whenever the output register is empty or draining.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) state <= ST_IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_pending) begin
                    load      = 1'b1;
                    state_nxt = ST_VALID;
                end
            end
            ST_VALID: begin
                if (M_STAMP_TREADY) begin
                    if (any_pending) load = 1'b1;
                    else             state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign M_STAMP_TVALID = (state == ST_VALID);

    // A slot being moved to the output this edge can take a new capture.
    always_comb begin
        taken     = load ? grant : '0;
        slot_free = ~pending | taken;
        accept    = STAMP_REQ & slot_free;
        drop      = STAMP_REQ & ~slot_free;
        drop_k    = '0;
        for (int i = 0; i < NUM_PORTS; i++) drop_k = drop_k + SUM_W'(drop[i]);
        // Clear zeroes the base but this cycle's drops still land.
        cnt_sum   = (DROP_CLEAR ? '0 : SUM_W'(DROP_COUNT)) + drop_k;
        cnt_nxt   = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[DROP_CNT_WIDTH-1:0];
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            pending       <= '0;
            snapshot      <= '0;
            M_STAMP_TDATA <= '0;
            M_STAMP_TUSER <= '0;
            last_grant    <= LAST_RST;
            DROP_FLAG     <= '0;
            DROP_COUNT    <= '0;
        end else begin
            pending <= (pending & ~taken) | accept;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (accept[i]) snapshot[i] <= STAMP_COUNTER;
            end
            if (load) begin
                M_STAMP_TDATA <= snapshot[grant_idx];
                M_STAMP_TUSER <= grant_idx;
                last_grant    <= grant_idx;
            end
            DROP_FLAG  <= (DROP_CLEAR ? '0 : DROP_FLAG) | drop;
            DROP_COUNT <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_nf10_stamp_arbiter.sv
// tb_nf10_stamp_arbiter
//   Directed stimulus with literal expectations, plus a per-cycle comparison
//   against a behavioural model (per-port one-deep slots, a held output beat,
//   round-robin pointer, integer drop counter).
module tb_nf10_stamp_arbiter;

    localparam int N  = 4;
    localparam int TW = 64;
    localparam int CW = 16;
    localparam int CNT_SAT = (1 << CW) - 1;

    logic          clk    = 1'b0;
    logic          rstn   = 1'b0;
    logic [TW-1:0] counter = '0;
    logic [N-1:0]  req    = '0;
    logic          tready = 1'b0;
    logic          dclr   = 1'b0;
    logic [TW-1:0] tdata;
    logic [1:0]    tuser;
    logic          tvalid;
    logic [N-1:0]  dflag;
    logic [CW-1:0] dcnt;

    always #5 clk = ~clk;

    nf10_stamp_arbiter #(
        .NUM_PORTS       (N),
        .TIMESTAMP_WIDTH (TW),
        .DROP_CNT_WIDTH  (CW)
    ) dut (
        .S_AXI_ACLK     (clk),
        .S_AXI_ARESETN  (rstn),
        .STAMP_COUNTER  (counter),
        .STAMP_REQ      (req),
        .M_STAMP_TDATA  (tdata),
        .M_STAMP_TUSER  (tuser),
        .M_STAMP_TVALID (tvalid),
        .M_STAMP_TREADY (tready),
        .DROP_FLAG      (dflag),
        .DROP_COUNT     (dcnt),
        .DROP_CLEAR     (dclr)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            m_vld;
    logic [63:0]   m_data;
    int            m_user;
    bit            m_pend [N];
    logic [63:0]   m_snap [N];
    int            m_last;
    logic [N-1:0]  m_flag;
    int            m_cnt;
    int            m_p;
    int            m_k;

    always @(posedge clk) begin
        if (!rstn) begin
            m_vld = 0; m_data = '0; m_user = 0; m_last = N - 1;
            m_flag = '0; m_cnt = 0;
            for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_snap[i] = '0; end
        end else begin
            // Output register takes the next stamp when empty or accepted.
            if (!m_vld || tready) begin
                m_vld = 0;
                for (int s = 1; s <= N; s++) begin
                    m_p = (m_last + s) % N;
                    if (!m_vld && m_pend[m_p]) begin
                        m_vld = 1; m_data = m_snap[m_p]; m_user = m_p;
                        m_pend[m_p] = 0; m_last = m_p;
                    end
                end
            end
            if (dclr) begin m_flag = '0; m_cnt = 0; end
            m_k = 0;
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (m_pend[i]) begin m_k++; m_flag[i] = 1'b1; end
                    else begin m_pend[i] = 1; m_snap[i] = counter; end
                end
            end
            m_cnt = (m_cnt + m_k > CNT_SAT) ? CNT_SAT : m_cnt + m_k;
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_tvalid", tvalid, m_vld);
            if (m_vld) begin
                chk("m_tdata", tdata, m_data);
                chk("m_tuser", tuser, m_user);
            end
            chk("m_drop_flag", dflag, m_flag);
            chk("m_drop_count", dcnt, m_cnt);
        end
    end

    int beats = 0;
    always @(posedge clk) if (rstn && tvalid && tready) beats++;

    // ---------------- directed stimulus ----------------
    initial begin
        int b0;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata",  tdata,  0);
        chk("rst_tuser",  tuser,  0);
        chk("rst_flag",   dflag,  0);
        chk("rst_count",  dcnt,   0);
        rstn = 1'b1; cmp_en = 1;

        // Single request, one-cycle latency
        counter = 64'h100; req = 4'b0100; tready = 1'b1;
        @(negedge clk); req = '0; counter = 64'h999;
        chk("single_latency", tvalid, 0);
        @(negedge clk);
        chk("single_tvalid", tvalid, 1);
        chk("single_tdata",  tdata,  64'h100);
        chk("single_tuser",  tuser,  2);
        @(negedge clk);
        chk("single_done", tvalid, 0);

        // Simultaneous requests right after reset: ports 0..3 in order
        rstn = 1'b0; @(negedge clk); rstn = 1'b1;
        counter = 64'h200; req = 4'hF;
        @(negedge clk); req = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("simul_tvalid", tvalid, 1);
            chk("simul_tuser",  tuser,  i);
            chk("simul_tdata",  tdata,  64'h200);
        end
        @(negedge clk);
        chk("simul_done", tvalid, 0);

        // Backpressure: held stable for 5 cycles, exactly one beat on release
        tready = 1'b0; counter = 64'h300; req = 4'b0001;
        @(negedge clk); req = '0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_tvalid", tvalid, 1);
            chk("bp_tdata",  tdata,  64'h300);
            chk("bp_tuser",  tuser,  0);
            @(negedge clk);
        end
        b0 = beats; tready = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_one_beat", beats - b0, 1);
        chk("bp_done", tvalid, 0);

        // Drop: output busy, port 1 requested twice, oldest kept
        tready = 1'b0; counter = 64'h5; req = 4'b0001;
        @(negedge clk); req = '0;
        @(negedge clk);
        counter = 64'h10; req = 4'b0010;
        @(negedge clk); counter = 64'h20;
        @(negedge clk); req = '0;
        chk("drop_flag",  dflag, 4'b0010);
        chk("drop_count", dcnt,  1);
        b0 = beats; tready = 1'b1;
        @(negedge clk);
        chk("drop_kept_tvalid", tvalid, 1);
        chk("drop_kept_tdata",  tdata,  64'h10);
        chk("drop_kept_tuser",  tuser,  1);
        @(negedge clk);
        chk("drop_beats", beats - b0, 2);
        chk("drop_idle",  tvalid, 0);
        dclr = 1'b1; @(negedge clk); dclr = 1'b0;
        chk("clr_flag",  dflag, 0);
        chk("clr_count", dcnt,  0);

        // Saturation: every slot full, output stalled, requests every cycle
        tready = 1'b0; counter = 64'h40; req = 4'hF;
        @(negedge clk);
        @(negedge clk);
        cmp_en = 0;
        repeat (16400) @(negedge clk);
        req = '0;
        @(negedge clk);
        chk("sat_count", dcnt,  16'hFFFF);
        chk("sat_flag",  dflag, 4'hF);
        cmp_en = 1;
        // Clear and drop in the same cycle: drops win
        dclr = 1'b1; req = 4'b0011;
        @(negedge clk); dclr = 1'b0; req = '0;
        chk("clrdrop_count", dcnt,  2);
        chk("clrdrop_flag",  dflag, 4'b0011);

        // Fairness: last grant 2, ports 1 and 3 pending -> 3 then 1
        rstn = 1'b0; @(negedge clk); rstn = 1'b1; tready = 1'b1;
        counter = 64'h500; req = 4'b0100;
        @(negedge clk); req = '0;
        @(negedge clk);
        chk("fair_pre_tuser", tuser, 2);
        @(negedge clk);
        counter = 64'h600; req = 4'b1010;
        @(negedge clk); req = '0;
        @(negedge clk);
        chk("fair_first",  tuser, 3);
        @(negedge clk);
        chk("fair_second", tuser, 1);
        chk("fair_tdata",  tdata, 64'h600);
        @(negedge clk);
        chk("fair_done", tvalid, 0);

        // Reset mid-operation discards everything, requests during reset ignored
        tready = 1'b0; counter = 64'h700; req = 4'b0111;
        @(negedge clk); req = '0;
        @(negedge clk);
        chk("mid_tvalid_before", tvalid, 1);
        rstn = 1'b0; req = 4'hF;
        @(negedge clk); rstn = 1'b1; req = '0;
        chk("mid_tvalid_after", tvalid, 0);
        chk("mid_count", dcnt,  0);
        chk("mid_flag",  dflag, 0);
        b0 = beats; tready = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_no_beats", beats - b0, 0);
        chk("mid_idle", tvalid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
